// File: rtl/booth_mac_sched.sv
// Operand scheduler and accumulator wrapped around a sequential Booth multiplier.
// Operand pairs are queued, the multiplier is launched once per pair, and the products are summed.
module booth_mac_sched #(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+4,
    parameter int DEPTH = 4,
    parameter int LAT   = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_M,
    input  logic [N-1:0]     in_Q,
    input  logic             in_last,
    output logic [N-1:0]     mult_M,
    output logic [N-1:0]     mult_Q,
    output logic             mult_rst,
    input  logic [2*N-1:0]   mult_Prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, ACC, DONE} state_t;

    state_t state, state_next;

    logic [2*N:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_next;
    logic             full;
    logic             push, pop;
    logic             last_r;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   sum;

    assign push = in_valid && !full;
    assign pop  = (state == IDLE) && (count != '0);
    assign sum  = {1'b0, acc} + (ACC_W+1)'(mult_Prod);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (AW+1)'(1);
        else if (!push && pop)
            count_next = count - (AW+1)'(1);
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_M, in_Q, in_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (count != '0) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (cnt == CW'(LAT-1)) state_next = ACC;
            ACC:  state_next = last_r ? DONE : IDLE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // mult_rst follows the upcoming state so it is high exactly while idle, loading or done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_M   <= '0;
            mult_Q   <= '0;
            last_r   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            mult_rst <= 1'b1;
        end else begin
            if (pop)
                {mult_M, mult_Q, last_r} <= mem[rd_ptr];
            if (state == LOAD)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + CW'(1);
            if (state == ACC) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end else if (state == DONE && out_ready) begin
                acc <= '0;
                ovf <= 1'b0;
            end
            mult_rst <= (state_next == IDLE) || (state_next == LOAD) || (state_next == DONE);
        end
    end

    assign in_ready  = !full;
    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign out_ovf   = ovf;
    assign busy      = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_booth_mac_sched.sv
// Scoreboard bench for booth_mac_sched with a behavioural fixed-latency multiplier.
module tb_booth_mac_sched;

    localparam int N     = 4;
    localparam int ACC_W = 2*N+4;
    localparam int DEPTH = 4;
    localparam int LAT   = N;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_M, in_Q;
    logic             in_last;
    logic [N-1:0]     mult_M, mult_Q;
    logic             mult_rst;
    logic [2*N-1:0]   mult_Prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             busy;

    int compared     = 0;
    int mismatched   = 0;
    int results_seen = 0;
    int model_acc    = 0;
    logic model_ovf  = 1'b0;
    logic [ACC_W:0] sb [$];
    int mcnt = 0;

    always #5 clk = ~clk;

    booth_mac_sched #(.N(N), .ACC_W(ACC_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_M(in_M), .in_Q(in_Q), .in_last(in_last),
        .mult_M(mult_M), .mult_Q(mult_Q), .mult_rst(mult_rst), .mult_Prod(mult_Prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
    );

    // Product is only correct after LAT clocks out of reset; before that it is deliberately wrong.
    always @(posedge clk) begin
        if (mult_rst)
            mcnt <= 0;
        else if (mcnt < LAT)
            mcnt <= mcnt + 1;
    end
    assign mult_Prod = (mcnt == LAT) ? (2*N)'(mult_M * mult_Q) : ~((2*N)'(mult_M * mult_Q));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelAccept(input logic [N-1:0] m, input logic [N-1:0] q, input logic last);
        int s;
        s = model_acc + int'(m) * int'(q);
        if (s >= (1 << ACC_W))
            model_ovf = 1'b1;
        model_acc = s % (1 << ACC_W);
        if (last) begin
            sb.push_back({model_ovf, ACC_W'(model_acc)});
            model_acc = 0;
            model_ovf = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic applyStimulus(input logic [N-1:0] m, input logic [N-1:0] q, input logic last);
        int waited = 0;
        in_M = m; in_Q = q; in_last = last; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("push_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        modelAccept(m, q, last);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResults(input int target);
        int n = 0;
        while (results_seen < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("result_count", results_seen, target);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    always @(negedge clk) begin
        logic [ACC_W:0] exp_v;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                exp_v = sb.pop_front();
                checkOutput("out_acc", 32'(out_acc), 32'(exp_v[ACC_W-1:0]));
                checkOutput("out_ovf", 32'(out_ovf), 32'(exp_v[ACC_W]));
            end
            results_seen++;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_M = '0; in_Q = '0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_mult_rst", 32'(mult_rst), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_acc", 32'(out_acc), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single last pair: edge-by-edge timing of the launch and the result.
        out_ready = 1'b0;
        applyStimulus(4'd13, 4'd11, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                checkOutput("e1_mult_rst", 32'(mult_rst), 1);
                checkOutput("e1_mult_M", 32'(mult_M), 13);
                checkOutput("e1_mult_Q", 32'(mult_Q), 11);
            end
            if (e == 2) checkOutput("e2_mult_rst", 32'(mult_rst), 0);
            if (e == 6) begin
                checkOutput("e6_out_valid", 32'(out_valid), 0);
                checkOutput("e6_mult_M_held", 32'(mult_M), 13);
            end
            if (e == 7) checkOutput("e7_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        waitResults(1);

        // Four pairs accumulated into one result.
        for (int i = 0; i < 4; i++)
            applyStimulus(4'd15, 4'd15, i == 3);
        waitResults(2);

        // Accumulator wrap with sticky overflow, then a clean result.
        for (int i = 0; i < 19; i++)
            applyStimulus(4'd15, 4'd15, i == 18);
        waitResults(3);
        applyStimulus(4'd2, 4'd3, 1'b1);
        waitResults(4);

        // Downstream stall: result holds while the FIFO fills up.
        out_ready = 1'b0;
        applyStimulus(4'd5, 4'd5, 1'b1);
        for (int n = 0; n < 50 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        checkOutput("stall_valid", 32'(out_valid), 1);
        for (int i = 1; i <= 4; i++)
            applyStimulus(4'd1, 4'(i), 1'b0);
        checkOutput("stall_full", 32'(in_ready), 0);
        in_M = 4'd2; in_Q = 4'd2; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk); #1;
            if (out_acc !== ACC_W'(25) || !out_valid || in_ready) begin
                checkOutput("stall_hold_acc", 32'(out_acc), 25);
                checkOutput("stall_hold_valid", 32'(out_valid), 1);
                checkOutput("stall_hold_ready", 32'(in_ready), 0);
            end
        end
        checkOutput("stall_end_acc", 32'(out_acc), 25);
        in_valid = 1'b0;
        out_ready = 1'b1;
        applyStimulus(4'd2, 4'd2, 1'b1);
        waitResults(6);

        // Reset in the middle of a multiply discards the partial sum.
        applyStimulus(4'd9, 4'd9, 1'b0);
        waitIdle();
        applyStimulus(4'd7, 4'd7, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_reset_run", 32'(mult_rst), 0);
        rst = 1'b1;
        #1;
        model_acc = 0;
        model_ovf = 1'b0;
        checkOutput("midrst_mult_rst", 32'(mult_rst), 1);
        checkOutput("midrst_mult_M", 32'(mult_M), 0);
        checkOutput("midrst_out_acc", 32'(out_acc), 0);
        checkOutput("midrst_in_ready", 32'(in_ready), 1);
        checkOutput("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(4'd3, 4'd5, 1'b1);
        waitResults(7);

        // Zero operands on either side.
        applyStimulus(4'd0, 4'd9, 1'b1);
        applyStimulus(4'd9, 4'd0, 1'b1);
        waitResults(9);
        waitIdle();
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
